muldiv_unit: RTL and testbench

Iterative HI/LO multiply/divide unit directly downstream of the register file. It consumes the A/B read-port data for MULT/MULTU/DIV/DIVU and holds the architectural HI and LO registers. It also services MTHI/MTLO writes and presents HI/LO for MFHI/MFLO. The control unit stalls on Busy.

---
 rtl/muldiv_unit_if.sv | 16 +
 rtl/muldiv_unit.sv | 88 ++++++++
 tb/tb_muldiv_unit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: operand, control and HI/LO result signals shared by the muldiv unit and its driver.
interface muldiv_unit_if #(parameter int WIDTH = 32);
  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Hi_We;
  logic             Lo_We;
  logic [WIDTH-1:0] W_Data;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  modport master(output Start, Op, A, B, Hi_We, Lo_We, W_Data, input Busy, Done, HI, LO);
  modport slave(input Start, Op, A, B, Hi_We, Lo_We, W_Data, output Busy, Done, HI, LO);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative signed/unsigned multiply and divide holding the HI/LO registers.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 6
) (
  input logic          Clk,
  input logic          Clr,
  muldiv_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t             state_q;
  logic               div_q, sq_q, sr_q, dz_q, done_q;
  logic [WIDTH-1:0]   m_q, x_q, hi_q, lo_q;
  logic [2*WIDTH-1:0] acc_q, acc_d, prod;
  logic [CNTW-1:0]    cnt_q;
  logic [WIDTH-1:0]   x_d, a_mag, b_mag, quo, rem, fix_hi, fix_lo;
  logic [WIDTH:0]     mul_sum, div_t, div_r;
  logic               sgn, div_ge;
  always_comb begin
    sgn     = ~bus.Op[0];
    a_mag   = (sgn && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    b_mag   = (sgn && bus.B[WIDTH-1]) ? -bus.B : bus.B;
    // m_q is multiplicand/divisor; x_q is multiplier (shifted right) or dividend (shifted left)
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (x_q[0] ? {1'b0, m_q} : '0);
    div_t   = {acc_q[2*WIDTH-1:WIDTH], x_q[WIDTH-1]};
    div_ge  = div_t >= {1'b0, m_q};
    div_r   = div_ge ? div_t - {1'b0, m_q} : div_t;
    acc_d   = div_q ? {div_r[WIDTH-1:0], acc_q[WIDTH-2:0], div_ge} : {mul_sum, acc_q[WIDTH-1:1]};
    x_d     = div_q ? x_q << 1 : x_q >> 1;
    prod    = sq_q ? -acc_q : acc_q;
    quo     = dz_q ? '1 : (sq_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
    rem     = sr_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    fix_hi  = div_q ? rem : prod[2*WIDTH-1:WIDTH];
    fix_lo  = div_q ? quo : prod[WIDTH-1:0];
  end
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state_q <= IDLE;
      div_q   <= 1'b0;
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
      m_q     <= '0;
      x_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.Hi_We) hi_q <= bus.W_Data;
          if (bus.Lo_We) lo_q <= bus.W_Data;
          if (bus.Start) begin
            div_q   <= bus.Op[1];
            sq_q    <= sgn & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
            sr_q    <= sgn & bus.A[WIDTH-1];
            dz_q    <= bus.Op[1] && (bus.B == '0);
            m_q     <= bus.Op[1] ? b_mag : a_mag;
            x_q     <= bus.Op[1] ? a_mag : b_mag;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q   <= acc_d;
          x_q     <= x_d;
          cnt_q   <= cnt_q + 1'b1;
          state_q <= (cnt_q == CNTW'(WIDTH - 1)) ? FIX : RUN;
        end
        FIX: begin
          hi_q    <= fix_hi;
          lo_q    <= fix_lo;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.Busy = state_q != IDLE;
  assign bus.Done = done_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit against an arithmetic reference of HI/LO results.
module tb_muldiv_unit;
  typedef struct {
    int          cyc;
    logic [63:0] v;
  } exp_t;
  logic        clk = 1'b0;
  logic        clr = 1'b0;
  int          cyc = 0;
  int          busy_until = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] ref_hi = '0;
  logic [31:0] ref_lo = '0;
  exp_t        sb[$];
  muldiv_unit_if #(.WIDTH(32)) bus();
  muldiv_unit #(.WIDTH(32), .CNTW(6)) dut(.Clk(clk), .Clr(clr), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", n, cyc, act, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb_, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb_ = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    if (op[1] && b == 0) return {a, 32'hFFFF_FFFF};
    case (op)
      2'd0: begin q = sa * sb_; return q; end
      2'd1: return ua * ub;
      2'd2: begin q = sa / sb_; r = sa % sb_; return {r[31:0], q[31:0]}; end
      default: return {32'(ua % ub), 32'(ua / ub)};
    endcase
  endfunction
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction
  task automatic step(input logic st, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic hw, input logic lw, input logic [31:0] wd);
    int e;
    @(negedge clk);
    bus.Start = st;
    bus.Op = op;
    bus.A = a;
    bus.B = b;
    bus.Hi_We = hw;
    bus.Lo_We = lw;
    bus.W_Data = wd;
    e = cyc + 1;
    if (e > busy_until) begin
      if (hw) ref_hi = wd;
      if (lw) ref_lo = wd;
      if (st) begin
        sb.push_back('{e + 33, model(op, a, b)});
        busy_until = e + 33;
      end
    end
  endtask
  task automatic idle();
    step(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 100 && cyc < busy_until; i++) idle();
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (clr) begin
        chk("busy", 64'(bus.Busy), 64'(cyc < busy_until));
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
          e = sb.pop_front();
          chk("done_pulse", 64'(bus.Done), 64'd1);
          ref_hi = e.v[63:32];
          ref_lo = e.v[31:0];
        end else begin
          chk("done_idle", 64'(bus.Done), 64'd0);
        end
        chk("hi", 64'(bus.HI), 64'(ref_hi));
        chk("lo", 64'(bus.LO), 64'(ref_lo));
      end
    end
  end
  initial begin
    bus.Start = 1'b0;
    bus.Op = 2'd0;
    bus.A = '0;
    bus.B = '0;
    bus.Hi_We = 1'b0;
    bus.Lo_We = 1'b0;
    bus.W_Data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hi", 64'(bus.HI), 64'd0);
    chk("reset_lo", 64'(bus.LO), 64'd0);
    chk("reset_busy", 64'(bus.Busy), 64'd0);
    chk("reset_done", 64'(bus.Done), 64'd0);
    @(negedge clk);
    clr = 1'b1;
    step(1'b1, 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
    wait_idle();
    step(1'b1, 2'd0, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0, 32'h0);
    wait_idle();
    step(1'b1, 2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 32'h0);
    wait_idle();
    step(1'b1, 2'd3, 32'd100, 32'd0, 1'b0, 1'b0, 32'h0);
    wait_idle();
    step(1'b1, 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
    wait_idle();
    step(1'b1, 2'd2, 32'hFFFF_FFF9, 32'd0, 1'b0, 1'b0, 32'h0);
    wait_idle();
    step(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h1234_5678);
    idle();
    step(1'b1, 2'd1, 32'd3, 32'd4, 1'b0, 1'b0, 32'h0);
    step(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 1'b1, 32'hDEAD_BEEF);
    repeat (5) idle();
    step(1'b1, 2'd0, 32'd7, 32'd7, 1'b0, 1'b0, 32'h0);
    wait_idle();
    step(1'b1, 2'd3, 32'd50, 32'd7, 1'b1, 1'b1, 32'hAAAA_5555);
    wait_idle();
    step(1'b1, 2'd0, 32'd123, 32'd456, 1'b0, 1'b0, 32'h0);
    repeat (9) idle();
    @(posedge clk);
    #2 clr = 1'b0;
    #1;
    chk("clr_hi", 64'(bus.HI), 64'd0);
    chk("clr_lo", 64'(bus.LO), 64'd0);
    chk("clr_busy", 64'(bus.Busy), 64'd0);
    chk("clr_done", 64'(bus.Done), 64'd0);
    sb.delete();
    ref_hi = '0;
    ref_lo = '0;
    busy_until = cyc;
    #1 clr = 1'b1;
    step(1'b1, 2'd1, 32'd9, 32'd9, 1'b0, 1'b0, 32'h0);
    wait_idle();
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)), pick(), pick(),
           $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom);
    for (int i = 0; i < 100 && sb.size() > 0; i++) idle();
    chk("drain", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
